// File: rtl/ahb_bridge_pkg.sv
// Shared constants, slave-interface state encoding and HTRANS helper for the AHB-to-APB bridge.
// No configuration macros are used in this file.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEF_REGION_SZ = 32'h0400_0000;

  typedef enum logic [2:0] {
    SLV_IDLE  = 3'd0,
    SLV_WDATA = 3'd1,
    SLV_RDATA = 3'd2,
    SLV_ERR1  = 3'd3,
    SLV_ERR2  = 3'd4
  } slv_state_e;

  // BUSY is never a real transfer; SEQ is treated like NONSEQ.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational bridge address decode: window hit and one-hot peripheral region select.
// Shared with the bridge top for APB Psel generation.
module ahb_addr_decode
  import ahb_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] REGION_SZ = ADDR_W'(DEF_REGION_SZ),
  parameter int                NUM_SEL   = 3
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               o_in_window,
  output logic [NUM_SEL-1:0] o_tempselx
);

  // One extra bit so the window size never wraps for a window ending at the top of the map.
  localparam logic [ADDR_W:0] REGION_W = (ADDR_W+1)'(REGION_SZ);
  localparam logic [ADDR_W:0] WINDOW_W = (ADDR_W+1)'(NUM_SEL) * REGION_W;

  logic [ADDR_W:0] w_offset;

  assign w_offset    = {1'b0, i_addr - BASE_ADDR};
  assign o_in_window = (i_addr >= BASE_ADDR) && (w_offset < WINDOW_W);

  always_comb begin
    o_tempselx = '0;
    for (int k = 0; k < NUM_SEL; k++) begin
      if (o_in_window &&
          (w_offset >= (ADDR_W+1)'(k) * REGION_W) &&
          (w_offset <  (ADDR_W+1)'(k + 1) * REGION_W))
        o_tempselx[k] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-side slave interface of the AHB-to-APB bridge: qualifies transfers, decodes the region,
// pipelines address/data/direction two deep. AHB_SLV_ERR_RESP_EN enables ERROR on unmapped hits.
//
// state | meaning
// IDLE  | no transfer in its data phase
// WDATA | write data phase in progress
// RDATA | read data phase in progress
// ERR1  | first ERROR cycle, wait state inserted via hready_err
// ERR2  | second ERROR cycle, transfer completes
module ahb_slave_if
  import ahb_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] REGION_SZ = ADDR_W'(DEF_REGION_SZ),
  parameter int                NUM_SEL   = 3
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [1:0]         Htrans,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  output logic               valid,
  output logic [NUM_SEL-1:0] tempselx,
  output logic [ADDR_W-1:0]  Haddr1,
  output logic [ADDR_W-1:0]  Haddr2,
  output logic [DATA_W-1:0]  Hwdata1,
  output logic [DATA_W-1:0]  Hwdata2,
  output logic               Hwritereg,
  output logic               Hwritereg1,
  output logic               wdata_vld,
  output logic [1:0]         Hresp,
  output logic               hready_err
);

  slv_state_e r_state, w_state_nxt;
  logic       w_in_window;
  logic       w_active;
  logic       w_err_req;
  logic       r_wdata_vld;

  ahb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .REGION_SZ(REGION_SZ),
    .NUM_SEL  (NUM_SEL)
  ) u_decode (
    .i_addr     (Haddr),
    .o_in_window(w_in_window),
    .o_tempselx (tempselx)
  );

  assign w_active  = htrans_active(Htrans);
  assign valid     = Hreadyin && w_active && w_in_window;
  assign wdata_vld = r_wdata_vld;

`ifdef AHB_SLV_ERR_RESP_EN
  assign w_err_req  = Hreadyin && w_active && !w_in_window;
  assign Hresp      = ((r_state == SLV_ERR1) || (r_state == SLV_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hready_err = (r_state != SLV_ERR1);
`else
  assign w_err_req  = 1'b0;
  assign Hresp      = HRESP_OKAY;
  assign hready_err = 1'b1;
`endif

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Haddr1     <= '0;
      Haddr2     <= '0;
      Hwdata1    <= '0;
      Hwdata2    <= '0;
      Hwritereg  <= 1'b0;
      Hwritereg1 <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1     <= Haddr;
      Haddr2     <= Haddr1;
      Hwdata1    <= Hwdata;
      Hwdata2    <= Hwdata1;
      Hwritereg  <= Hwrite;
      Hwritereg1 <= Hwritereg;
    end
  end

  // Pulse lands together with the write data captured into Hwdata1.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) r_wdata_vld <= 1'b0;
    else          r_wdata_vld <= Hreadyin && (r_state == SLV_WDATA);
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) r_state <= SLV_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLV_IDLE, SLV_WDATA, SLV_RDATA: begin
        if (valid)          w_state_nxt = Hwrite ? SLV_WDATA : SLV_RDATA;
        else if (w_err_req) w_state_nxt = SLV_ERR1;
        else if (Hreadyin)  w_state_nxt = SLV_IDLE;
      end
      // Error cycles self-time: hready_err pulls the bus ready low during ERR1.
      SLV_ERR1: w_state_nxt = SLV_ERR2;
      SLV_ERR2: w_state_nxt = SLV_IDLE;
      default:  w_state_nxt = SLV_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed scenarios plus a randomized run against a
// transfer-level reference model. Honours AHB_SLV_ERR_RESP_EN when it is defined for the build.
module tb_ahb_slave_if;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] RSZ  = 32'h0400_0000;
  localparam int          NSEL = 3;
`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        Hclk = 1'b0;
  logic        Hresetn, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic        Hwritereg, Hwritereg1, wdata_vld, hready_err;
  logic [1:0]  Hresp;

  int checks = 0;
  int errors = 0;

  always #5 Hclk = ~Hclk;

  ahb_slave_if dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .valid(valid), .tempselx(tempselx),
    .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
    .Hwritereg(Hwritereg), .Hwritereg1(Hwritereg1), .wdata_vld(wdata_vld),
    .Hresp(Hresp), .hready_err(hready_err)
  );

  // Apply one cycle of bus inputs on the falling edge, settle, return for sampling.
  task automatic drive(input logic rdy, input logic [1:0] tr, input logic [31:0] a,
                       input logic [31:0] d, input logic wr);
    @(negedge Hclk);
    Hreadyin = rdy; Htrans = tr; Haddr = a; Hwdata = d; Hwrite = wr;
    #1;
  endtask

  task automatic test_reset();
    Hresetn = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00; Haddr = '0; Hwdata = '0; Hwrite = 1'b0;
    repeat (2) @(negedge Hclk);
    #1;
    checks++; if (Haddr1 !== 32'h0 || Haddr2 !== 32'h0) begin errors++;
      $display("FAIL rst_addr: got %h/%h want 0/0", Haddr1, Haddr2); end
    checks++; if (Hwdata1 !== 32'h0 || Hwdata2 !== 32'h0) begin errors++;
      $display("FAIL rst_wdata: got %h/%h want 0/0", Hwdata1, Hwdata2); end
    checks++; if ({Hwritereg, Hwritereg1, wdata_vld} !== 3'b000) begin errors++;
      $display("FAIL rst_ctrl: got %b want 000", {Hwritereg, Hwritereg1, wdata_vld}); end
    checks++; if (Hresp !== 2'b00 || hready_err !== 1'b1) begin errors++;
      $display("FAIL rst_resp: got %b/%b want 00/1", Hresp, hready_err); end
    @(negedge Hclk);
    Hresetn = 1'b1;
  endtask

  task automatic test_single_write();
    drive(1'b1, 2'b10, 32'h8000_0001, 32'h0, 1'b1);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b001) begin errors++;
      $display("FAIL wr_decode: got valid=%b sel=%b want 1/001", valid, tempselx); end
    drive(1'b1, 2'b00, 32'h0, 32'h0000_00A3, 1'b0);
    checks++; if (Haddr1 !== 32'h8000_0001 || Hwritereg !== 1'b1) begin errors++;
      $display("FAIL wr_stage1: got %h/%b want 80000001/1", Haddr1, Hwritereg); end
    checks++; if (wdata_vld !== 1'b0) begin errors++;
      $display("FAIL wr_early_vld: got %b want 0", wdata_vld); end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    checks++; if (Hwdata1 !== 32'h0000_00A3 || wdata_vld !== 1'b1) begin errors++;
      $display("FAIL wr_data: got %h/%b want 000000a3/1", Hwdata1, wdata_vld); end
    checks++; if (Haddr2 !== 32'h8000_0001 || Hwritereg1 !== 1'b1) begin errors++;
      $display("FAIL wr_stage2: got %h/%b want 80000001/1", Haddr2, Hwritereg1); end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    checks++; if (wdata_vld !== 1'b0) begin errors++;
      $display("FAIL wr_pulse_len: got %b want 0", wdata_vld); end
  endtask

  task automatic test_single_read();
    drive(1'b1, 2'b10, 32'h8000_00A2, 32'h0, 1'b0);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b001) begin errors++;
      $display("FAIL rd_decode: got valid=%b sel=%b want 1/001", valid, tempselx); end
    drive(1'b1, 2'b00, 32'h0, 32'h1234_5678, 1'b0);
    checks++; if (Haddr1 !== 32'h8000_00A2 || Hwritereg !== 1'b0) begin errors++;
      $display("FAIL rd_stage1: got %h/%b want 800000a2/0", Haddr1, Hwritereg); end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    checks++; if (wdata_vld !== 1'b0) begin errors++;
      $display("FAIL rd_no_vld: got %b want 0", wdata_vld); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b10, 32'h8400_0010, 32'h0, 1'b1);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b010) begin errors++;
      $display("FAIL b2b_sel0: got valid=%b sel=%b want 1/010", valid, tempselx); end
    drive(1'b1, 2'b10, 32'h8800_0020, 32'hCAFE_0001, 1'b1);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b100) begin errors++;
      $display("FAIL b2b_sel1: got valid=%b sel=%b want 1/100", valid, tempselx); end
    drive(1'b1, 2'b00, 32'h0, 32'hCAFE_0002, 1'b0);
    checks++; if (Haddr1 !== 32'h8800_0020 || Haddr2 !== 32'h8400_0010) begin errors++;
      $display("FAIL b2b_addr: got %h/%h want 88000020/84000010", Haddr1, Haddr2); end
    checks++; if (wdata_vld !== 1'b1 || Hwdata1 !== 32'hCAFE_0001) begin errors++;
      $display("FAIL b2b_vld0: got %b/%h want 1/cafe0001", wdata_vld, Hwdata1); end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    checks++; if (wdata_vld !== 1'b1 || Hwdata1 !== 32'hCAFE_0002 || Hwdata2 !== 32'hCAFE_0001) begin
      errors++; $display("FAIL b2b_vld1: got %b/%h/%h want 1/cafe0002/cafe0001", wdata_vld, Hwdata1, Hwdata2); end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    checks++; if (wdata_vld !== 1'b0) begin errors++;
      $display("FAIL b2b_end: got %b want 0", wdata_vld); end
  endtask

  task automatic test_wait_states();
    drive(1'b1, 2'b10, 32'h8000_0040, 32'h0000_1111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 32'h0, 32'h0000_5A5A, 1'b0);
      checks++; if (Haddr1 !== 32'h8000_0040 || Hwdata1 !== 32'h0000_1111 || wdata_vld !== 1'b0) begin
        errors++; $display("FAIL wait_hold%0d: got %h/%h/%b want 80000040/00001111/0", i, Haddr1, Hwdata1, wdata_vld); end
    end
    drive(1'b1, 2'b00, 32'h0, 32'h0000_5A5A, 1'b0);
    checks++; if (Haddr1 !== 32'h8000_0040 || wdata_vld !== 1'b0) begin errors++;
      $display("FAIL wait_last: got %h/%b want 80000040/0", Haddr1, wdata_vld); end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    checks++; if (Hwdata1 !== 32'h0000_5A5A || wdata_vld !== 1'b1 || Haddr2 !== 32'h8000_0040) begin
      errors++; $display("FAIL wait_release: got %h/%b/%h want 00005a5a/1/80000040", Hwdata1, wdata_vld, Haddr2); end
  endtask

  task automatic test_out_of_window();
    logic [1:0] er;
    logic       eh;
    // Window edges, probed with BUSY so no transfer is started.
    drive(1'b1, 2'b01, 32'h8BFF_FFFF, 32'h0, 1'b0);
    checks++; if (tempselx !== 3'b100 || valid !== 1'b0) begin errors++;
      $display("FAIL edge_top_in: got sel=%b valid=%b want 100/0", tempselx, valid); end
    drive(1'b1, 2'b01, 32'h8C00_0000, 32'h0, 1'b0);
    checks++; if (tempselx !== 3'b000) begin errors++;
      $display("FAIL edge_top_out: got sel=%b want 000", tempselx); end
    drive(1'b1, 2'b01, 32'h7FFF_FFFF, 32'h0, 1'b0);
    checks++; if (tempselx !== 3'b000) begin errors++;
      $display("FAIL edge_below: got sel=%b want 000", tempselx); end
    drive(1'b1, 2'b10, 32'h9000_0000, 32'h0, 1'b1);
    checks++; if (valid !== 1'b0 || tempselx !== 3'b000 || Hresp !== 2'b00 || hready_err !== 1'b1) begin
      errors++; $display("FAIL oow_addr: got %b/%b/%b/%b want 0/000/00/1", valid, tempselx, Hresp, hready_err); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
      er = (ERR_EN && i < 2) ? 2'b01 : 2'b00;
      eh = !(ERR_EN && i == 0);
      checks++; if (Hresp !== er || hready_err !== eh) begin errors++;
        $display("FAIL oow_resp%0d: got %b/%b want %b/%b", i, Hresp, hready_err, er, eh); end
    end
    checks++; if (wdata_vld !== 1'b0) begin errors++;
      $display("FAIL oow_no_vld: got %b want 0", wdata_vld); end
  endtask

  task automatic test_reset_mid_write();
    drive(1'b1, 2'b10, 32'h8000_0080, 32'h0, 1'b1);
    drive(1'b1, 2'b00, 32'h0, 32'h0000_0077, 1'b0);
    Hresetn = 1'b0;
    #1;
    checks++; if (Haddr1 !== 32'h0 || Hwritereg !== 1'b0 || wdata_vld !== 1'b0) begin errors++;
      $display("FAIL rstw_async: got %h/%b/%b want 0/0/0", Haddr1, Hwritereg, wdata_vld); end
    @(posedge Hclk); #1;
    checks++; if (wdata_vld !== 1'b0 || Hwdata1 !== 32'h0) begin errors++;
      $display("FAIL rstw_abort: got %b/%h want 0/0", wdata_vld, Hwdata1); end
    @(negedge Hclk);
    Hresetn = 1'b1;
    drive(1'b1, 2'b10, 32'h8400_0004, 32'h0, 1'b1);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b010) begin errors++;
      $display("FAIL rstw_next_dec: got %b/%b want 1/010", valid, tempselx); end
    drive(1'b1, 2'b00, 32'h0, 32'h0000_BEEF, 1'b0);
    checks++; if (Haddr1 !== 32'h8400_0004 || Hwritereg !== 1'b1) begin errors++;
      $display("FAIL rstw_next_s1: got %h/%b want 84000004/1", Haddr1, Hwritereg); end
    drive(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    checks++; if (wdata_vld !== 1'b1 || Hwdata1 !== 32'h0000_BEEF) begin errors++;
      $display("FAIL rstw_next_vld: got %b/%h want 1/0000beef", wdata_vld, Hwdata1); end
  endtask

  // Reference model: last two accepted samples, whether the open data phase is a write,
  // and how many ERROR cycles remain.
  task automatic test_random(input int n);
    logic [31:0] h1a, h2a, h1d, h2d;
    logic        h1w, h2w, pend, ewv, nwv;
    int          err_cnt;
    h1a = '0; h2a = '0; h1d = '0; h2d = '0; h1w = 1'b0; h2w = 1'b0;
    pend = 1'b0; ewv = 1'b0; err_cnt = 0;
    @(negedge Hclk);
    Hresetn = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00; Haddr = '0; Hwdata = '0; Hwrite = 1'b0;
    @(negedge Hclk);
    Hresetn = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic        rdy, wr, inw, ev, act, eh;
      logic [1:0]  tr, er;
      logic [31:0] a, d;
      logic [2:0]  es;
      longint      la;
      rdy = (err_cnt > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tr  = 2'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      d   = $urandom;
      case ($urandom_range(0, 7))
        0, 1, 2: a = BASE + RSZ * $urandom_range(0, 2) + ($urandom % RSZ);
        3:       a = 32'h8BFF_FFFF;
        4:       a = 32'h8C00_0000;
        5:       a = 32'h7FFF_FFFF;
        6:       a = $urandom;
        default: a = BASE;
      endcase
      drive(rdy, tr, a, d, wr);
      la  = longint'(a);
      inw = (la >= longint'(BASE)) && (la < longint'(BASE) + NSEL * longint'(RSZ));
      es  = inw ? 3'(1 << ((la - longint'(BASE)) / longint'(RSZ))) : 3'b000;
      act = (tr == 2'b10) || (tr == 2'b11);
      ev  = rdy && act && inw;
      er  = (err_cnt > 0) ? 2'b01 : 2'b00;
      eh  = (err_cnt != 2);
      checks++; if (valid !== ev || tempselx !== es) begin errors++;
        $display("FAIL rnd_decode @%0d a=%h: got %b/%b want %b/%b", i, a, valid, tempselx, ev, es); end
      checks++; if (Haddr1 !== h1a || Haddr2 !== h2a) begin errors++;
        $display("FAIL rnd_addr @%0d: got %h/%h want %h/%h", i, Haddr1, Haddr2, h1a, h2a); end
      checks++; if (Hwdata1 !== h1d || Hwdata2 !== h2d) begin errors++;
        $display("FAIL rnd_wdata @%0d: got %h/%h want %h/%h", i, Hwdata1, Hwdata2, h1d, h2d); end
      checks++; if (Hwritereg !== h1w || Hwritereg1 !== h2w || wdata_vld !== ewv) begin errors++;
        $display("FAIL rnd_ctrl @%0d: got %b%b%b want %b%b%b", i, Hwritereg, Hwritereg1, wdata_vld, h1w, h2w, ewv); end
      checks++; if (Hresp !== er || hready_err !== eh) begin errors++;
        $display("FAIL rnd_resp @%0d: got %b/%b want %b/%b", i, Hresp, hready_err, er, eh); end
      nwv = (err_cnt == 0) && rdy && pend;
      if (err_cnt > 0) err_cnt--;
      else if (rdy) begin
        pend = ev && wr;
        if (ERR_EN && act && !inw) err_cnt = 2;
      end
      if (rdy) begin
        h2a = h1a; h1a = a; h2d = h1d; h1d = d; h2w = h1w; h1w = wr;
      end
      ewv = nwv;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_out_of_window();
    test_reset_mid_write();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
